// File: rtl/lcd_reader.sv
// lcd_reader: Nios II multi-cycle custom instruction that performs HD44780
// read cycles (RW=1). dataa[0] selects RS (0 = busy flag/address,
// 1 = DDRAM/CGRAM data). dataa[1] selects poll mode. Poll mode forces RS=0 and
// repeats status reads until BF=0, or until MAX_POLLS reads have been made.
// This block never drives the LCD data bus. The top level releases the bus
// while lcd_rw=1.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   clk_en       CI clock enable; everything freezes while low
//   start        CI start, accepted only in IDLE
//   dataa        [0] RS select, [1] poll mode; other bits ignored
//   datab        ignored
//   result       [7:0] byte read, [23:16] polls used, [31] timeout
//   done         one-cycle completion pulse, result valid from this cycle
//   lcd_data_in  DB7..DB0 from the pad
//   lcd_rs       register select
//   lcd_rw       1 while a read cycle is in progress
//   lcd_enable   E strobe
module lcd_reader #(
  parameter int SETUP_CYC   = 3,
  parameter int EHIGH_CYC   = 13,
  parameter int RECOVER_CYC = 25,
  parameter int MAX_POLLS   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done,
  input  logic [7:0]  lcd_data_in,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_enable
);

  localparam logic [15:0] SETUP_LAST   = 16'(SETUP_CYC - 1);
  localparam logic [15:0] EHIGH_LAST   = 16'(EHIGH_CYC - 1);
  localparam logic [15:0] RECOVER_LAST = 16'(RECOVER_CYC - 1);
  localparam logic [7:0]  POLL_LIMIT   = 8'(MAX_POLLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EHIGH,
    S_RECOVER,
    S_FINISH
  } state_t;

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic        poll, poll_d;
  logic [7:0]  polls, polls_d;
  logic [7:0]  rd_byte, rd_byte_d;
  logic        timeout, timeout_d;
  logic [31:0] result_d;
  logic        done_d;
  logic        rs_d, rw_d, en_d;

  // datab and dataa[31:2] are part of the CI interface but carry nothing here.
  logic unused_inputs;
  assign unused_inputs = ^{datab, dataa[31:2]};

  // All LCD strobes are registered so that an asynchronous reset drops them
  // at once. clk_en gates every register, which gives an exact freeze and
  // resume.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      poll       <= 1'b0;
      polls      <= '0;
      rd_byte    <= '0;
      timeout    <= 1'b0;
      result     <= '0;
      done       <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_rw     <= 1'b0;
      lcd_enable <= 1'b0;
    end else if (clk_en) begin
      state      <= state_d;
      cnt        <= cnt_d;
      poll       <= poll_d;
      polls      <= polls_d;
      rd_byte    <= rd_byte_d;
      timeout    <= timeout_d;
      result     <= result_d;
      done       <= done_d;
      lcd_rs     <= rs_d;
      lcd_rw     <= rw_d;
      lcd_enable <= en_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    poll_d    = poll;
    polls_d   = polls;
    rd_byte_d = rd_byte;
    timeout_d = timeout;
    result_d  = result;
    done_d    = 1'b0;
    rs_d      = lcd_rs;
    rw_d      = lcd_rw;
    en_d      = lcd_enable;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          // lcd_rs doubles as the latched RS select for the whole operation.
          rs_d      = dataa[0] & ~dataa[1];
          poll_d    = dataa[1];
          polls_d   = '0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          rw_d      = 1'b1;
          en_d      = 1'b0;
          state_d   = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_d   = '0;
          en_d    = 1'b1;
          state_d = S_EHIGH;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end

      S_EHIGH: begin
        if (cnt == EHIGH_LAST) begin
          cnt_d     = '0;
          en_d      = 1'b0;
          rd_byte_d = lcd_data_in;
          // Compare before incrementing so the count can never pass the limit.
          if (polls != POLL_LIMIT) begin
            polls_d = polls + 8'd1;
          end
          state_d = S_RECOVER;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end

      S_RECOVER: begin
        if (cnt == RECOVER_LAST) begin
          cnt_d = '0;
          if (poll && rd_byte[7]) begin
            if (polls < POLL_LIMIT) begin
              state_d = S_SETUP;
            end else begin
              timeout_d = 1'b1;
              state_d   = S_FINISH;
            end
          end else begin
            state_d = S_FINISH;
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end

      S_FINISH: begin
        result_d = {timeout, 7'b0, polls, 8'b0, rd_byte};
        done_d   = 1'b1;
        rw_d     = 1'b0;
        rs_d     = 1'b0;
        en_d     = 1'b0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        rw_d    = 1'b0;
        rs_d    = 1'b0;
        en_d    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lcd_reader.sv
// tb_lcd_reader: directed test of lcd_reader. The bench plays the LCD side
// from a per-operation table of bytes, advanced on each falling E. It measures
// the latency, the E pulse count and the total E-high cycles, and checks the
// result word and the bus-discipline invariants.
module tb_lcd_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_en = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;
  logic [31:0] result;
  logic        done;
  logic [7:0]  lcd_data_in;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_enable;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  rd_tab [8];
  int          rd_idx = 0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  lcd_reader #(
    .SETUP_CYC  (3),
    .EHIGH_CYC  (13),
    .RECOVER_CYC(25),
    .MAX_POLLS  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .start      (start),
    .dataa      (dataa),
    .datab      (datab),
    .result     (result),
    .done       (done),
    .lcd_data_in(lcd_data_in),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_enable (lcd_enable)
  );

  // The next read returns the next table entry. The DUT samples on the edge
  // that drops E, so advancing on that negedge presents the following byte.
  assign lcd_data_in = rd_tab[rd_idx];
  always @(negedge lcd_enable) if (rd_idx < 7) rd_idx = rd_idx + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] exp_res,
                        input int exp_lat, input int exp_pulses, input int exp_ehigh,
                        input logic exp_rs, input int freeze_at);
    int n, eh, pulses, rs_bad, e_bad, rw_low;
    logic e_prev;
    n = 0; eh = 0; pulses = 0; rs_bad = 0; e_bad = 0; rw_low = 0; e_prev = 1'b0;
    rd_idx = 0;
    @(negedge clk);
    dataa = a; start = 1'b1; clk_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dataa = '0;
    while (n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (lcd_enable) eh++;
      if (lcd_enable && !e_prev) pulses++;
      e_prev = lcd_enable;
      if (lcd_rw && lcd_rs !== exp_rs) rs_bad++;
      if (lcd_enable && !lcd_rw) e_bad++;
      if (!lcd_rw) rw_low++;
      if (n == 10) check({tag, "_result_held"}, result, last_res);
      // A start while busy must be ignored.
      if (n == 20) begin start = 1'b1; dataa = ~a; end
      if (n == 21) begin start = 1'b0; dataa = '0; end
      if (freeze_at > 0 && n == freeze_at) clk_en = 1'b0;
      if (freeze_at > 0 && n == freeze_at + 10) clk_en = 1'b1;
    end
    check({tag, "_done"},    {31'b0, done}, 32'd1);
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_result"},  result, exp_res);
    check({tag, "_pulses"},  pulses, exp_pulses);
    check({tag, "_ehigh"},   eh, exp_ehigh);
    check({tag, "_rs"},      rs_bad, 0);
    check({tag, "_e_no_rw"}, e_bad, 0);
    check({tag, "_rw_held"}, rw_low, 0);
    check({tag, "_rw_off"},  {31'b0, lcd_rw}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_1cyc"}, {31'b0, done}, 32'd0);
    check({tag, "_rs_off"},    {31'b0, lcd_rs}, 32'd0);
    check({tag, "_res_keep"},  result, exp_res);
    last_res = exp_res;
  endtask

  initial begin
    int dcnt;
    foreach (rd_tab[i]) rd_tab[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", result, 32'h0);
    check("rst_done",   {31'b0, done}, 32'd0);
    check("rst_rw",     {31'b0, lcd_rw}, 32'd0);
    check("rst_rs",     {31'b0, lcd_rs}, 32'd0);
    check("rst_e",      {31'b0, lcd_enable}, 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);

    // A start with clk_en low is ignored.
    @(negedge clk); start = 1'b1; clk_en = 1'b0;
    @(posedge clk); #1; start = 1'b0; clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("noen_rw",   {31'b0, lcd_rw}, 32'd0);
    check("noen_done", {31'b0, done}, 32'd0);

    // 1: status read
    rd_tab[0] = 8'h25;
    run_op("status", 32'h0, 32'h0001_0025, 42, 1, 13, 1'b0, 0);

    // 2: data read
    rd_tab[0] = 8'h41;
    run_op("data", 32'h1, 32'h0001_0041, 42, 1, 13, 1'b1, 0);

    // 3: poll with BF=1 for three reads
    rd_tab[0] = 8'h85; rd_tab[1] = 8'h85; rd_tab[2] = 8'h85; rd_tab[3] = 8'h07;
    run_op("poll", 32'h2, 32'h0004_0007, 42 + 3 * 41, 4, 52, 1'b0, 0);

    // 4: BF stuck, timeout after 4 reads
    foreach (rd_tab[i]) rd_tab[i] = 8'h80;
    run_op("timeout", 32'h2, 32'h8004_0080, 42 + 3 * 41, 4, 52, 1'b0, 0);

    // 5: clk_en low for 10 cycles during EHIGH
    foreach (rd_tab[i]) rd_tab[i] = 8'h3C;
    run_op("freeze", 32'h0, 32'h0001_003C, 52, 1, 23, 1'b0, 5);

    // 6: reset in mid-EHIGH
    rd_tab[0] = 8'h25; rd_idx = 0;
    @(negedge clk); dataa = '0; start = 1'b1; clk_en = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort_e_before", {31'b0, lcd_enable}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_e",      {31'b0, lcd_enable}, 32'd0);
    check("abort_rw",     {31'b0, lcd_rw}, 32'd0);
    check("abort_done",   {31'b0, done}, 32'd0);
    check("abort_result", result, 32'h0);
    last_res = '0;
    @(negedge clk); reset = 1'b1;
    dcnt = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    check("abort_idle_rw", {31'b0, lcd_rw}, 32'd0);
    rd_tab[0] = 8'h25;
    run_op("after_rst", 32'h0, 32'h0001_0025, 42, 1, 13, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
